// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared codes and types for the seven-segment display scanner
package seg_disp_pkg;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic {GAP, ON} scan_state_e;
endpackage

// File: rtl/lzb_filter.sv
// lzb_filter: combinational leading-zero blanker; digit 0 is never blanked
module lzb_filter import seg_disp_pkg::*; #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] din,
  output logic [4*NUM_DIGITS-1:0] dout
);
  logic lead;
  always_comb begin
    dout = din;
    lead = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead = lead && (din[4*k +: 4] == 4'd0);
      if (lead) dout[4*k +: 4] = BLANK_CODE;
    end
  end
endmodule

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: double-buffered time-multiplexed scanner for a common-anode seven-segment display
// Define DIGIT_SCAN_LZB_EN to blank leading zeros when a word is committed.
module digit_scan_mux import seg_disp_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GAP_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  output logic [3:0]              digit_bin,
  output logic [NUM_DIGITS-1:0]   an_n
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2((CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES) + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [W-1:0] BLANK_WORD = {NUM_DIGITS{BLANK_CODE}};

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [W-1:0]          pend_q, pend_d, disp_q, disp_d, disp_in;
  logic                  pend_vld_q, pend_vld_d, in_ready_q, in_ready_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  bcd_digit_t            digit_bin_q, digit_bin_d;
  logic                  gap_done, on_done, commit, accept;

`ifdef DIGIT_SCAN_LZB_EN
  lzb_filter #(.NUM_DIGITS(NUM_DIGITS)) u_lzb (.din(pend_q), .dout(disp_in));
`else
  assign disp_in = pend_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GAP;
      cnt_q       <= '0;
      idx_q       <= LAST;
      pend_q      <= BLANK_WORD;
      disp_q      <= BLANK_WORD;
      pend_vld_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      an_n_q      <= '1;
      digit_bin_q <= BLANK_CODE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      disp_q      <= disp_d;
      pend_vld_q  <= pend_vld_d;
      in_ready_q  <= in_ready_d;
      an_n_q      <= an_n_d;
      digit_bin_q <= digit_bin_d;
    end
  end

  always_comb begin
    gap_done = state_q == GAP && cnt_q == CW'(GAP_CYCLES - 1);
    on_done  = state_q == ON && cnt_q == CW'(CLK_DIV - 1);
    state_d  = gap_done ? ON : on_done ? GAP : state_q;
    cnt_d    = (gap_done || on_done) ? '0 : cnt_q + 1'b1;
    idx_d    = !gap_done ? idx_q : idx_q == LAST ? '0 : idx_q + 1'b1;
  end

  // Outputs lag state by one edge so anode and code always switch together.
  always_comb begin
    commit      = gap_done && idx_q == LAST && pend_vld_q;
    accept      = in_valid && in_ready_q;
    pend_d      = accept ? in_bcd : pend_q;
    pend_vld_d  = accept || (pend_vld_q && !commit);
    disp_d      = commit ? disp_in : disp_q;
    in_ready_d  = !pend_vld_d;
    an_n_d      = state_q == ON ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    digit_bin_d = state_q == ON ? disp_q[{idx_q, 2'b00} +: 4] : BLANK_CODE;
  end

  assign in_ready  = in_ready_q;
  assign an_n      = an_n_q;
  assign digit_bin = digit_bin_q;
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed scoreboard bench for digit_scan_mux (4 digits, CLK_DIV=4, GAP_CYCLES=2)
module tb_digit_scan_mux;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic [3:0]  digit_bin;
  logic [3:0]  an_n;
  logic [15:0] tx_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] s;
  int tests = 0;
  int fails = 0;

`ifdef DIGIT_SCAN_LZB_EN
  localparam logic [15:0] SHOW_0042 = 16'hFF42;
  localparam logic [15:0] SHOW_0000 = 16'hFFF0;
`else
  localparam logic [15:0] SHOW_0042 = 16'h0042;
  localparam logic [15:0] SHOW_0000 = 16'h0000;
`endif

  digit_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .GAP_CYCLES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bcd(in_bcd),
    .digit_bin(digit_bin),
    .an_n(an_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle to the next falling edge, retiring an accepted word and presenting the next.
  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(negedge clk);
    if (acc) in_valid = 1'b0;
    if (!in_valid && rst_n && tx_q.size() > 0) begin
      in_bcd = tx_q.pop_front();
      in_valid = 1'b1;
    end
  endtask

  task automatic check_frame(input logic rdy);
    logic [15:0] w;
    logic [3:0] a;
    int n = 0;
    while (an_n !== 4'b1110 && n < 64) begin
      tick();
      n++;
    end
    chk("frame_start", an_n, 4'b1110);
    chk("frame_ready", in_ready, rdy);
    w = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
    for (int d = 0; d < 4; d++) begin
      a = ~(4'b0001 << d);
      for (int c = 0; c < 4; c++) begin
        chk("on_anode", an_n, a);
        chk("on_digit", digit_bin, w[4*d +: 4]);
        tick();
      end
      for (int g = 0; g < 2; g++) begin
        chk("gap_anode", an_n, 4'hF);
        chk("gap_digit", digit_bin, 4'hF);
        tick();
      end
    end
    chk("wrap_to_digit0", an_n, 4'b1110);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_bcd = '0;
    repeat (3) @(negedge clk);
    chk("rst_anode", an_n, 4'hF);
    chk("rst_digit", digit_bin, 4'hF);
    chk("rst_ready", in_ready, 1'b0);
    tx_q = '{16'h1234, 16'h1111, 16'h2222, 16'hA009, 16'h0042, 16'h0000};
    exp_q = '{16'hFFFF, 16'h1234, 16'h1111, 16'h2222, 16'hA009, SHOW_0042, SHOW_0000};
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", in_ready, 1'b1);
    tick();
    chk("ready_after_accept", in_ready, 1'b0);
    chk("blank_edge2", an_n, 4'hF);
    tick();
    chk("first_lit_edge3", an_n, 4'b1110);
    for (int f = 0; f < 7; f++) check_frame(f == 6);
    tx_q.push_back(16'h9876);
    for (int n = 0; n < 40 && an_n !== 4'b1011; n++) tick();
    s = SHOW_0000;
    chk("pre_reset_digit2_anode", an_n, 4'b1011);
    chk("pre_reset_digit2", digit_bin, s[11:8]);
    chk("pre_reset_pending", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_anode", an_n, 4'hF);
    chk("midrst_digit", digit_bin, 4'hF);
    chk("midrst_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_midrst", in_ready, 1'b1);
    exp_q = '{16'hFFFF, 16'hFFFF, 16'h5678};
    check_frame(1'b1);
    tx_q.push_back(16'h5678);
    check_frame(1'b1);
    check_frame(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Time-multiplexed scanner for a common-anode multi-digit seven-segment display. Accepts a packed BCD word through a valid/ready handshake, double-buffers it so a display frame never tears, and steps through digits one at a time. Drives the 4-bit digit code into the seven-segment decoder and the active-low anode enables to the board.

## Interface
- `NUM_DIGITS`, 4: digits scanned, legal 2..8; digit 0 is least significant.
- `CLK_DIV`, 50000: cycles each digit's anode is held on, ≥1.
- `GAP_CYCLES`, 8: all-anodes-off cycles between digits (anti-ghosting), ≥1.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: `in_bcd` holds a new value.
- `in_ready` output 1: the pending buffer is free.
- `in_bcd` input 4*NUM_DIGITS: packed digits, digit k at [4k+3:4k].
- `digit_bin` output 4: code of the currently lit digit, to the decoder.
- `an_n` output NUM_DIGITS: active-low anode enables; at most one bit is low.

## Operation
- **Buffers**
  - `pend_q` / `pend_vld`: pending word and its flag.
  - `disp_q`: the word currently being shown.
- **Accept:** on `in_valid && in_ready`, `in_bcd` → `pend_q` and `pend_vld` ← 1.
  - `in_ready` = `!pend_vld`, forced 0 while `rst_n` is low.
  - A second word is not accepted until the first is committed.
- **Commit**
  - Happens only at the frame boundary, i.e. the cycle the FSM leaves GAP with `idx == NUM_DIGITS-1`.
  - At commit, `pend_q` → `disp_q` and `pend_vld` ← 0.
  - If accept and commit fall in the same cycle, commit uses the old `pend_q`, and the new word is not accepted because `in_ready` was 0.
- **FSM:** two states, GAP and ON. There is a prescaler `cnt` and a digit index `idx` (width `$clog2(NUM_DIGITS)`).
  - **GAP:** `an_n` all 1s, `digit_bin` = 4'hF. After `GAP_CYCLES` cycles, go to ON.
    - If `idx == NUM_DIGITS-1`, wrap `idx` to 0; otherwise increment it.
  - **ON:** `an_n[idx]` = 0, `digit_bin` = `disp_q[idx]`. After `CLK_DIV` cycles, go to GAP.
  - `cnt` reloads to 0 on every state change.
- **Digit codes:** codes 10–15 in `in_bcd` are passed through unchanged. The decoder renders them blank.
- **Reset values**
  - State GAP, `idx` = NUM_DIGITS-1, so the first digit lit after reset is digit 0.
  - `cnt` = 0.
  - `disp_q` and `pend_q` all 4'hF, i.e. a blank display.
  - `pend_vld` = 0.
  - `an_n` all 1s, `digit_bin` = 4'hF, `in_ready` = 0.
- **Reset mid-frame:** pending data is discarded and the display blanks on the next edge.

## Timing
- `an_n` and `digit_bin` are registered and change on the same edge, so there is never a cycle where the code and anode disagree.
- Frame length = NUM_DIGITS × (CLK_DIV + GAP_CYCLES) cycles.
- First ON cycle for digit 0 comes GAP_CYCLES+1 edges after `rst_n` rises.
- `in_ready` rises on the first edge after reset is released.
- Accept → `in_ready` low on the next edge.
- Worst-case accept-to-display latency = one frame + GAP_CYCLES + 1 cycles.
- `in_ready` returns high the cycle after commit.

## Configuration
- **`DIGIT_SCAN_LZB_EN` defined:** leading-zero blanking is applied at commit.
  - Scanning from digit NUM_DIGITS-1 downward, each digit equal to 0 is stored as 4'hF until the first non-zero digit.
  - Digit 0 is never blanked.
- **Undefined:** `pend_q` is copied to `disp_q` verbatim. No blanking logic is present.

## Structure
- **Shared package `seg_disp_pkg`:**
  - `localparam BLANK_CODE = 4'hF`.
  - Typedef `bcd_digit_t` (logic [3:0]).
  - Enum `scan_state_e` {GAP, ON}.
- **Sub-module `lzb_filter`:** combinational leading-zero blanker, instantiated only under `DIGIT_SCAN_LZB_EN`.
- Prescaler, FSM and buffers stay in the top module.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=4, GAP_CYCLES=2 (frame = 24 cycles).
- **Reset:** hold `rst_n`=0 for 3 cycles.
  - During reset: `an_n`=4'b1111, `digit_bin`=4'hF, `in_ready`=0.
  - `an_n`=4'b1110 first appears 3 edges after release.
- **Load and scan:** send `in_bcd`=16'h1234 right after reset.
  - It commits at the first frame boundary.
  - In the next frame, `digit_bin` cycles 4,3,2,1 with `an_n` 1110, 1101, 1011, 0111, 4 cycles each, and 2 blank cycles between digits.
- **Backpressure:** send 16'h1111, then hold `in_valid` with 16'h2222.
  - `in_ready` stays 0 until the commit of 1111.
  - 2222 is accepted the cycle after commit and displayed one frame later.
  - No frame ever mixes 1 and 2 digits.
- **Wrap and invalid codes:** send 16'hA009.
  - Digit 3 outputs 4'hA (passed through).
  - `idx` wraps 3→0 with exactly 2 GAP cycles in between.
- **`DIGIT_SCAN_LZB_EN`:**
  - 16'h0042 displays F,F,4,2.
  - 16'h0000 displays F,F,F,0.
  - Without the macro, 16'h0042 displays 0,0,4,2.
- **Mid-frame reset:** assert `rst_n`=0 while digit 2 is lit with a word pending.
  - Next edge: blank, `pend_vld`=0.
  - After release the display stays blank until a new word is accepted and committed.
